// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped 2-bit BHT plus tagged BTB, trained from EX.
// Optional BP_STATS_EN builds saturating branch/mispredict counters; otherwise stats read 0.
module branch_predictor #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] if_pc,
    output logic                  pred_taken,
    output logic [DATA_WIDTH-1:0] pred_target,
    input  logic                  ex_valid,
    input  logic [DATA_WIDTH-1:0] ex_pc,
    input  logic                  ex_taken,
    input  logic [DATA_WIDTH-1:0] ex_target,
    input  logic                  ex_pred_taken,
    input  logic [DATA_WIDTH-1:0] ex_pred_target,
    output logic                  mispredict,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_mispredicts
);

    localparam int unsigned Entries = 1 << INDEX_BITS;
    localparam int unsigned TagW    = DATA_WIDTH - INDEX_BITS - 2;

    logic [1:0]            bht_q        [Entries];
    logic                  btb_valid_q  [Entries];
    logic [TagW-1:0]       btb_tag_q    [Entries];
    logic [DATA_WIDTH-1:0] btb_target_q [Entries];

    logic [INDEX_BITS-1:0] if_idx, ex_idx;
    logic [TagW-1:0]       if_tag, ex_tag;
    logic                  btb_hit;
    logic                  unused_pc_bits;

    assign if_idx = if_pc[INDEX_BITS+1:2];
    assign ex_idx = ex_pc[INDEX_BITS+1:2];
    assign if_tag = if_pc[DATA_WIDTH-1:INDEX_BITS+2];
    assign ex_tag = ex_pc[DATA_WIDTH-1:INDEX_BITS+2];

    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    // Prediction reads registered state only; no bypass from a same-cycle training write.
    always_comb begin
        btb_hit     = btb_valid_q[if_idx] && (btb_tag_q[if_idx] == if_tag);
        pred_taken  = btb_hit && bht_q[if_idx][1];
        pred_target = pred_taken ? btb_target_q[if_idx] : if_pc + DATA_WIDTH'(4);
    end

    always_comb begin
        mispredict = ex_valid && ((ex_taken != ex_pred_taken) ||
                     (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));
        redirect_pc = ex_taken ? ex_target : ex_pc + DATA_WIDTH'(4);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < int'(Entries); i++) begin
                bht_q[i]        <= 2'b01;
                btb_valid_q[i]  <= 1'b0;
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= '0;
            end
        end else if (ex_valid) begin
            // BHT is untagged: the counter trains even when the BTB entry belongs to an alias.
            if (ex_taken) begin
                if (bht_q[ex_idx] != 2'b11) begin
                    bht_q[ex_idx] <= bht_q[ex_idx] + 2'b01;
                end
                btb_valid_q[ex_idx]  <= 1'b1;
                btb_tag_q[ex_idx]    <= ex_tag;
                btb_target_q[ex_idx] <= ex_target;
            end else if (bht_q[ex_idx] != 2'b00) begin
                bht_q[ex_idx] <= bht_q[ex_idx] - 2'b01;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_q, stat_mispredicts_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            if (ex_valid && (stat_branches_q != 32'hFFFF_FFFF)) begin
                stat_branches_q <= stat_branches_q + 32'd1;
            end
            if (mispredict && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
                stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`else
    assign stat_branches    = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: expectations queued at drive time, popped at negedge.
module tb_branch_predictor;

    logic        clk;
    logic        rstn;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    branch_predictor #(
        .DATA_WIDTH (32),
        .INDEX_BITS (6)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int unsigned SelPt = 0, SelPtg = 1, SelMis = 2, SelRed = 3, SelSb = 4, SelSm = 5;

    typedef struct {
        string       tag;
        int unsigned sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_vec;
    int   n_miss;

`ifdef BP_STATS_EN
    localparam bit StatsOn = 1'b1;
`else
    localparam bit StatsOn = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int unsigned sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic push_pred(input string tag, input logic t, input logic [31:0] tgt);
        push({tag, ".pt"}, SelPt, {31'd0, t});
        push({tag, ".ptg"}, SelPtg, tgt);
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] got;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                SelPt:   got = {31'd0, pred_taken};
                SelPtg:  got = pred_target;
                SelMis:  got = {31'd0, mispredict};
                SelRed:  got = redirect_pc;
                SelSb:   got = stat_branches;
                default: got = stat_mispredicts;
            endcase
            check(e.tag, got, e.exp);
        end
    endtask

    task automatic ex_set(input logic v, input logic [31:0] pc, input logic t,
                          input logic [31:0] tgt, input logic pt, input logic [31:0] ptg);
        ex_valid       = v;
        ex_pc          = pc;
        ex_taken       = t;
        ex_target      = tgt;
        ex_pred_taken  = pt;
        ex_pred_target = ptg;
    endtask

    task automatic ex_idle();
        ex_set(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rstn   = 1'b0;
        if_pc  = 32'h100;
        // Taken branch applied while in reset must not train anything.
        ex_set(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        next_cycle();
        push_pred("rst", 1'b0, 32'h104);
        push("rst.mis", SelMis, 32'd1);
        push("rst.red", SelRed, 32'h80);
        drain();
        next_cycle();
        rstn = 1'b1;
        ex_idle();
        push_pred("post_rst", 1'b0, 32'h104);
        push("post_rst.mis", SelMis, 32'd0);
        push("post_rst.sb", SelSb, 32'd0);
        push("post_rst.sm", SelSm, 32'd0);
        drain();

        // Same-cycle fetch and train: old prediction now, new one next cycle.
        next_cycle();
        ex_set(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        push_pred("same_cyc_old", 1'b0, 32'h104);
        push("train1.mis", SelMis, 32'd1);
        push("train1.red", SelRed, 32'h80);
        drain();
        next_cycle();
        ex_idle();
        push_pred("same_cyc_new", 1'b1, 32'h80);
        drain();

        // Three more taken: 10 -> 11 -> 11 -> 11 (saturate high).
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            ex_set(1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
            push("taken_ok.mis", SelMis, 32'd0);
            drain();
        end
        next_cycle();
        ex_set(1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        push("nt1.mis", SelMis, 32'd1);
        push("nt1.red", SelRed, 32'h104);
        drain();
        next_cycle();
        ex_idle();
        push_pred("sat_hi_wt", 1'b1, 32'h80);
        drain();
        next_cycle();
        ex_set(1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        drain();
        next_cycle();
        ex_idle();
        push_pred("wnt", 1'b0, 32'h104);
        drain();

        // Two more not-taken: 01 -> 00 -> 00, then one taken must land on 01.
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            ex_set(1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
            push("nt_ok.mis", SelMis, 32'd0);
            drain();
        end
        next_cycle();
        ex_set(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        drain();
        next_cycle();
        ex_idle();
        push_pred("sat_lo_wnt", 1'b0, 32'h104);
        drain();
        next_cycle();
        ex_set(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        drain();
        next_cycle();
        ex_idle();
        push_pred("back_wt", 1'b1, 32'h80);
        drain();

        // Aliasing: 0x200 shares index 0 with 0x100 but has a different tag.
        next_cycle();
        if_pc = 32'h200;
        push_pred("alias_miss", 1'b0, 32'h204);
        drain();
        next_cycle();
        ex_set(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 32'h204);
        drain();
        next_cycle();
        ex_idle();
        if_pc = 32'h100;
        push_pred("alias_shared_ctr", 1'b0, 32'h104);
        drain();

        // Mispredict and redirect.
        next_cycle();
        ex_set(1'b1, 32'h40, 1'b1, 32'h200, 1'b0, 32'h44);
        push("mis_nt2t", SelMis, 32'd1);
        push("red_nt2t", SelRed, 32'h200);
        drain();
        next_cycle();
        ex_set(1'b1, 32'h40, 1'b0, 32'h200, 1'b1, 32'h200);
        push("mis_t2nt", SelMis, 32'd1);
        push("red_t2nt", SelRed, 32'h44);
        drain();
        next_cycle();
        ex_set(1'b1, 32'h80, 1'b1, 32'h304, 1'b1, 32'h300);
        push("mis_tgt", SelMis, 32'd1);
        push("red_tgt", SelRed, 32'h304);
        drain();
        next_cycle();
        ex_set(1'b0, 32'h80, 1'b1, 32'h304, 1'b1, 32'h300);
        push("mis_novalid", SelMis, 32'd0);
        push("red_novalid", SelRed, 32'h304);
        drain();
        next_cycle();
        if_pc = 32'hFFFF_FFFC;
        push_pred("wrap", 1'b0, 32'h0);
        drain();

        // Fresh reset, then 5 branches with 2 mispredicts.
        next_cycle();
        rstn = 1'b0;
        ex_idle();
        if_pc = 32'h10;
        drain();
        next_cycle();
        rstn = 1'b1;
        push("stat_rst.sb", SelSb, 32'd0);
        push("stat_rst.sm", SelSm, 32'd0);
        drain();
        next_cycle();
        ex_set(1'b1, 32'h10, 1'b1, 32'h8, 1'b1, 32'h8);
        drain();
        next_cycle();
        ex_set(1'b1, 32'h10, 1'b0, 32'h8, 1'b1, 32'h8);
        drain();
        next_cycle();
        ex_set(1'b1, 32'h10, 1'b0, 32'h8, 1'b0, 32'h14);
        drain();
        next_cycle();
        ex_set(1'b1, 32'h10, 1'b1, 32'h8, 1'b0, 32'h14);
        drain();
        next_cycle();
        ex_set(1'b1, 32'h10, 1'b0, 32'h8, 1'b0, 32'h14);
        drain();
        next_cycle();
        ex_idle();
        push("stat_br", SelSb, StatsOn ? 32'd5 : 32'd0);
        push("stat_mis", SelSm, StatsOn ? 32'd2 : 32'd0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the pipelined RISC-V core. At fetch it gives a taken/not-taken guess and a next-PC target. In EX it takes the resolved outcome from the branch resolution logic (the `taken` result) and trains its tables. It also raises the mispredict/redirect signal that flushes the front end. Tables are a direct-mapped 2-bit-counter BHT plus a tagged BTB, indexed by PC word address.

## Interface
- DATA_WIDTH, 32, width of PCs and targets
- INDEX_BITS, 6, log2 of table entries (default 64 entries)
- clk  input  1  clock, all state updates on rising edge
- rstn  input  1  synchronous, active-low reset
- if_pc  input  DATA_WIDTH  PC of the instruction being fetched
- pred_taken  output  1  prediction for if_pc (1 = redirect fetch to pred_target)
- pred_target  output  DATA_WIDTH  predicted next PC
- ex_valid  input  1  a conditional branch is resolving in EX this cycle
- ex_pc  input  DATA_WIDTH  PC of the resolving branch
- ex_taken  input  1  resolved outcome
- ex_target  input  DATA_WIDTH  resolved branch target (pc + imm)
- ex_pred_taken  input  1  prediction made for this branch at fetch, piped down
- ex_pred_target  input  DATA_WIDTH  target predicted at fetch, piped down
- mispredict  output  1  flush/redirect request
- redirect_pc  output  DATA_WIDTH  correct next PC when mispredict = 1
- stat_branches  output  32  resolved-branch count (BP_STATS_EN)
- stat_mispredicts  output  32  mispredict count (BP_STATS_EN)

## Operation
- Index: idx = pc[INDEX_BITS+1:2]. Tag: pc[DATA_WIDTH-1:INDEX_BITS+2].
- Per entry state:
  - bht[idx]: 2-bit saturating counter. 00 SNT, 01 WNT, 10 WT, 11 ST.
  - btb_valid[idx], btb_tag[idx], btb_target[idx].
- Predict (combinational from registered state):
  - hit = btb_valid[idx] & (btb_tag[idx] == tag(if_pc)).
  - pred_taken = hit & bht[idx][1].
  - pred_target = pred_taken ? btb_target[idx] : if_pc + 4. Addition is modulo 2^DATA_WIDTH.
- Train (rising edge, only when ex_valid = 1 and rstn = 1, at idx(ex_pc)):
  - Counter: ex_taken increments it, saturating at 11. ~ex_taken decrements it, saturating at 00.
  - BTB: when ex_taken = 1, write valid = 1, tag(ex_pc), ex_target, overwriting any alias. When ex_taken = 0, leave the BTB unchanged.
  - The counter is updated on every valid branch, whether the BTB tag matches or not. BHT entries are untagged.
- Mispredict (combinational):
  - mispredict = ex_valid & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & (ex_target != ex_pred_target))).
  - redirect_pc = ex_taken ? ex_target : ex_pc + 4. It is driven the same way when mispredict = 0.
- ex_valid = 0 means no state change, and mispredict is 0.

## Timing
- Prediction latency is 0 cycles: pred_* depend only on if_pc and the stored state.
- A training write becomes visible to prediction on the cycle after the edge.
- Same-index read and write in one cycle: prediction uses the pre-update value. There is no bypass.
- Reset (rstn = 0 at an edge):
  - Every bht entry goes to 01 (WNT).
  - Every btb_valid goes to 0. Tags and targets go to 0.
  - Stat counters go to 0.
  - Reset overrides a concurrent ex_valid update.
- Output values during and right after reset:
  - pred_taken = 0 and pred_target = if_pc + 4 until a taken branch has trained.
  - mispredict and redirect_pc are combinational and follow the ex_* inputs even during reset. The pipeline is expected to hold ex_valid = 0 while in reset.

## Configuration
- BP_STATS_EN defined:
  - stat_branches increments on each edge with ex_valid = 1.
  - stat_mispredicts increments on each edge with mispredict = 1.
  - Both saturate at 32'hFFFF_FFFF.
- BP_STATS_EN undefined: both ports remain and are tied to 0. No counter logic is built.

## Test plan
- **Reset state:** reset, then if_pc = 0x100. Expect pred_taken = 0 and pred_target = 0x104. Apply ex_valid = 1 during reset; state must be unchanged afterwards.
- **Training:** two taken resolutions with ex_pc = 0x100, ex_target = 0x80. Expect:
  - After the first, pred_taken = 1 and pred_target = 0x80 (WNT→WT).
  - After two not-taken resolutions, pred_taken = 0 (ST→WT→WNT). Check the 11 and 00 saturation.
- **Mispredict:** ex_valid = 1, ex_pred_taken = 0, ex_taken = 1, ex_target = 0x200. Expect mispredict = 1 and redirect_pc = 0x200. Then ex_pred_taken = 1, ex_taken = 0, ex_pc = 0x40. Expect mispredict = 1 and redirect_pc = 0x44.
- **Target mismatch:** both taken, ex_pred_target = 0x300, ex_target = 0x304. Expect mispredict = 1.
- **Aliasing:** train 0x100 taken (INDEX_BITS = 6), then fetch 0x200 (same idx, different tag). Expect pred_taken = 0, with the counter shared.
- **Same-cycle read/write and stats:**
  - Fetch and train the same PC in one cycle. Expect the old prediction that cycle and the new one the next cycle.
  - With BP_STATS_EN: run 5 branches with 2 mispredicts. Expect stat_branches = 5 and stat_mispredicts = 2.
